// File: rtl/cr_huf_comp_st_reader.sv
// Read side of the Huffman symbol-table queue: scans a captured table in index order and
// streams each valid entry downstream, then pulses read-done to release the queue.
module cr_huf_comp_st_reader #(
  parameter int unsigned MAX_SYMBOL_TABLE_DEPTH = 584,
  parameter int unsigned SYM_WIDTH              = 6,
  parameter int unsigned PTR_WIDTH              = 10,
  parameter int unsigned SEQID_WIDTH            = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  sym_buf_full,
  input  logic [PTR_WIDTH-1:0]                  sym_buf_wr_ptr,
  input  logic [MAX_SYMBOL_TABLE_DEPTH-1:0]     st_val,
  input  logic [MAX_SYMBOL_TABLE_DEPTH*SYM_WIDTH-1:0] st_symbol,
  input  logic [MAX_SYMBOL_TABLE_DEPTH*8-1:0]   st_extra,
  input  logic [MAX_SYMBOL_TABLE_DEPTH*4-1:0]   st_extra_length,
  input  logic [SEQID_WIDTH-1:0]                st_seq_id,
  input  logic                                  st_build_error,
  output logic                                  sa_val,
  input  logic                                  sa_rdy,
  output logic [SYM_WIDTH-1:0]                  sa_symbol,
  output logic [7:0]                            sa_extra,
  output logic [3:0]                            sa_extra_length,
  output logic [PTR_WIDTH-1:0]                  sa_index,
  output logic                                  sa_tbl_end,
  output logic                                  sa_tbl_err,
  output logic [SEQID_WIDTH-1:0]                sa_seq_id,
  output logic                                  sa_st_read_done
);

  localparam int unsigned Depth = MAX_SYMBOL_TABLE_DEPTH;

  typedef enum logic [1:0] {StIdle, StScan, StDone, StWaitClr} state_e;

  state_e               state_q;
  logic [PTR_WIDTH-1:0] idx_q;
  logic [PTR_WIDTH-1:0] cnt_q;
  logic                 err_q;

  logic [SYM_WIDTH-1:0] sym_arr [Depth];
  logic [7:0]           ext_arr [Depth];
  logic [3:0]           len_arr [Depth];

  for (genvar g = 0; g < Depth; g++) begin : g_unpack
    assign sym_arr[g] = st_symbol[g*SYM_WIDTH +: SYM_WIDTH];
    assign ext_arr[g] = st_extra[g*8 +: 8];
    assign len_arr[g] = st_extra_length[g*4 +: 4];
  end

  logic                 slot_free;
  logic                 scan_more;
  logic                 cur_val;
  logic [PTR_WIDTH-1:0] wr_clamp;
  logic [PTR_WIDTH-1:0] idx_inc;

  assign slot_free = !sa_val || sa_rdy;
  assign scan_more = idx_q < cnt_q;
  // Only consumed while scan_more holds, so idx_q is always in range when it matters.
  assign cur_val   = st_val[idx_q];
  assign wr_clamp  = (sym_buf_wr_ptr > PTR_WIDTH'(Depth)) ? PTR_WIDTH'(Depth) : sym_buf_wr_ptr;
  assign idx_inc   = idx_q + PTR_WIDTH'(1);

  // Done strobes are raised on the transition into StDone so they are visible during that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      cnt_q           <= '0;
      err_q           <= 1'b0;
      sa_val          <= 1'b0;
      sa_symbol       <= '0;
      sa_extra        <= '0;
      sa_extra_length <= '0;
      sa_index        <= '0;
      sa_tbl_end      <= 1'b0;
      sa_tbl_err      <= 1'b0;
      sa_seq_id       <= '0;
      sa_st_read_done <= 1'b0;
    end else begin
      sa_st_read_done <= 1'b0;
      sa_tbl_end      <= 1'b0;
      sa_tbl_err      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sym_buf_full) begin
            sa_seq_id <= st_seq_id;
            if (st_build_error) begin
              err_q           <= 1'b1;
              state_q         <= StDone;
              sa_st_read_done <= 1'b1;
              sa_tbl_end      <= 1'b1;
              sa_tbl_err      <= 1'b1;
            end else begin
              cnt_q   <= wr_clamp;
              idx_q   <= '0;
              state_q <= StScan;
            end
          end
        end
        StScan: begin
          if (sa_val && sa_rdy) sa_val <= 1'b0;
          if (scan_more) begin
            if (!cur_val) begin
              idx_q <= idx_inc;
            end else if (slot_free) begin
              sa_val          <= 1'b1;
              sa_symbol       <= sym_arr[idx_q];
              sa_extra        <= ext_arr[idx_q];
              sa_extra_length <= len_arr[idx_q];
              sa_index        <= idx_q;
              idx_q           <= idx_inc;
            end
          end else if (slot_free) begin
            state_q         <= StDone;
            sa_st_read_done <= 1'b1;
            sa_tbl_end      <= 1'b1;
            sa_tbl_err      <= err_q;
          end
        end
        StDone: begin
          err_q   <= 1'b0;
          state_q <= StWaitClr;
        end
        StWaitClr: begin
          if (!sym_buf_full) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_huf_comp_st_reader.sv
// Bench for cr_huf_comp_st_reader: a table-level model predicts the emitted entry stream,
// one negedge monitor checks every handshake and done strobe against it.
module tb_cr_huf_comp_st_reader;
  localparam int D  = 584;
  localparam int SW = 6;
  localparam int PW = 10;
  localparam int QW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              sym_buf_full;
  logic [PW-1:0]     sym_buf_wr_ptr;
  logic [D-1:0]      st_val;
  logic [D*SW-1:0]   st_symbol;
  logic [D*8-1:0]    st_extra;
  logic [D*4-1:0]    st_extra_length;
  logic [QW-1:0]     st_seq_id;
  logic              st_build_error;
  logic              sa_val;
  logic              sa_rdy;
  logic [SW-1:0]     sa_symbol;
  logic [7:0]        sa_extra;
  logic [3:0]        sa_extra_length;
  logic [PW-1:0]     sa_index;
  logic              sa_tbl_end;
  logic              sa_tbl_err;
  logic [QW-1:0]     sa_seq_id;
  logic              sa_st_read_done;

  cr_huf_comp_st_reader dut (
    .clk             (clk),
    .rst             (rst),
    .sym_buf_full    (sym_buf_full),
    .sym_buf_wr_ptr  (sym_buf_wr_ptr),
    .st_val          (st_val),
    .st_symbol       (st_symbol),
    .st_extra        (st_extra),
    .st_extra_length (st_extra_length),
    .st_seq_id       (st_seq_id),
    .st_build_error  (st_build_error),
    .sa_val          (sa_val),
    .sa_rdy          (sa_rdy),
    .sa_symbol       (sa_symbol),
    .sa_extra        (sa_extra),
    .sa_extra_length (sa_extra_length),
    .sa_index        (sa_index),
    .sa_tbl_end      (sa_tbl_end),
    .sa_tbl_err      (sa_tbl_err),
    .sa_seq_id       (sa_seq_id),
    .sa_st_read_done (sa_st_read_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {int idx; int sym; int ext; int len;} ent_t;
  ent_t exp_q[$];
  ent_t e;
  int   got_idx[$];
  int   got_sym[$];

  int   sym_t[D];
  int   ext_t[D];
  int   len_t[D];
  bit   val_t[D];

  int   n_chk = 0;
  int   n_fail = 0;
  bit   exp_err;
  int   exp_seq;
  int   first_val_cyc;
  int   done_cyc;
  int   done_cnt = 0;
  int   acc_cnt = 0;
  int   start_n;

  bit            p_stall = 1'b0;
  logic [SW-1:0] p_sym;
  logic [7:0]    p_ext;
  logic [3:0]    p_len;
  logic [PW-1:0] p_idx;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        chk("stall_val", 64'(sa_val), 64'd1);
        chk("stall_sym", 64'(sa_symbol), 64'(p_sym));
        chk("stall_ext", 64'(sa_extra), 64'(p_ext));
        chk("stall_len", 64'(sa_extra_length), 64'(p_len));
        chk("stall_idx", 64'(sa_index), 64'(p_idx));
      end
      if (sa_val && first_val_cyc < 0) first_val_cyc = cyc;
      if (sa_val && sa_rdy) begin
        if (exp_q.size() == 0) begin
          chk("spurious_entry", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("entry_idx", 64'(sa_index), 64'(e.idx));
          chk("entry_sym", 64'(sa_symbol), 64'(e.sym));
          chk("entry_ext", 64'(sa_extra), 64'(e.ext));
          chk("entry_len", 64'(sa_extra_length), 64'(e.len));
          chk("entry_seq", 64'(sa_seq_id), 64'(exp_seq));
        end
        got_idx.push_back(int'(sa_index));
        got_sym.push_back(int'(sa_symbol));
        acc_cnt++;
      end
      if (sa_st_read_done || sa_tbl_end) begin
        chk("read_done", 64'(sa_st_read_done), 64'd1);
        chk("tbl_end", 64'(sa_tbl_end), 64'd1);
        chk("tbl_err", 64'(sa_tbl_err), 64'(exp_err));
        chk("pending_at_done", 64'(exp_q.size()), 64'd0);
        chk("done_seq", 64'(sa_seq_id), 64'(exp_seq));
        done_cnt++;
        done_cyc = cyc;
      end
      p_stall = sa_val && !sa_rdy;
      p_sym = sa_symbol;
      p_ext = sa_extra;
      p_len = sa_extra_length;
      p_idx = sa_index;
    end
  end

  task automatic clear_table();
    for (int i = 0; i < D; i++) begin
      val_t[i] = 1'b0;
      sym_t[i] = (i * 7 + 3) % 64;
      ext_t[i] = (i * 13 + 1) % 256;
      len_t[i] = i % 16;
    end
  endtask

  // Expected stream: every valid entry below min(wr_ptr, D), ascending.
  task automatic build_model(input int n, input bit err);
    int lim;
    exp_q.delete();
    lim = (n > D) ? D : n;
    if (!err)
      for (int i = 0; i < lim; i++)
        if (val_t[i]) exp_q.push_back('{idx: i, sym: sym_t[i], ext: ext_t[i], len: len_t[i]});
  endtask

  task automatic start_table(input int n, input bit err, input int seq);
    for (int i = 0; i < D; i++) begin
      st_val[i] = val_t[i];
      st_symbol[i*SW +: SW] = SW'(sym_t[i]);
      st_extra[i*8 +: 8] = 8'(ext_t[i]);
      st_extra_length[i*4 +: 4] = 4'(len_t[i]);
    end
    sym_buf_wr_ptr = PW'(n);
    st_build_error = err;
    st_seq_id = QW'(seq);
    exp_err = err;
    exp_seq = seq;
    build_model(n, err);
    got_idx.delete();
    got_sym.delete();
    first_val_cyc = -1;
    done_cyc = -1;
    sa_rdy = 1'b1;
    @(posedge clk); #1;
    start_n = cyc;
    sym_buf_full = 1'b1;
  endtask

  task automatic wait_done(input bit bp, input int budget);
    int d0;
    int c;
    d0 = done_cnt;
    c = 0;
    while (c < budget && done_cnt == d0) begin
      sa_rdy = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      @(posedge clk); #1;
      c++;
    end
    chk("done_seen", 64'(done_cnt - d0), 64'd1);
    sa_rdy = 1'b1;
  endtask

  // Table stays full for a while: no re-read, then release the queue.
  task automatic finish_table();
    int d0;
    int a0;
    d0 = done_cnt;
    a0 = acc_cnt;
    repeat (5) begin @(posedge clk); #1; end
    chk("no_reread_done", 64'(done_cnt), 64'(d0));
    chk("no_reread_entry", 64'(acc_cnt), 64'(a0));
    sym_buf_full = 1'b0;
    st_build_error = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int d0;
    int a0;
    int c;
    rst = 1'b1;
    sym_buf_full = 1'b0;
    sym_buf_wr_ptr = '0;
    st_val = '0;
    st_symbol = '0;
    st_extra = '0;
    st_extra_length = '0;
    st_seq_id = '0;
    st_build_error = 1'b0;
    sa_rdy = 1'b0;
    exp_err = 1'b0;
    exp_seq = 0;
    first_val_cyc = -1;
    done_cyc = -1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_val", 64'(sa_val), 64'd0);
    chk("rst_done", 64'(sa_st_read_done), 64'd0);
    chk("rst_end", 64'(sa_tbl_end), 64'd0);
    chk("rst_idx", 64'(sa_index), 64'd0);
    chk("rst_seq", 64'(sa_seq_id), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic: three valid entries, symbols 5/9/2.
    clear_table();
    for (int i = 0; i < 3; i++) val_t[i] = 1'b1;
    sym_t[0] = 5; sym_t[1] = 9; sym_t[2] = 2;
    start_table(3, 1'b0, 8'h21);
    wait_done(1'b0, 50);
    chk("basic_first_val_cyc", 64'(first_val_cyc - start_n), 64'd2);
    chk("basic_done_cyc", 64'(done_cyc - start_n), 64'd5);
    chk("basic_count", 64'(got_idx.size()), 64'd3);
    if (got_sym.size() == 3) begin
      chk("basic_sym0", 64'(got_sym[0]), 64'd5);
      chk("basic_sym1", 64'(got_sym[1]), 64'd9);
      chk("basic_sym2", 64'(got_sym[2]), 64'd2);
    end
    finish_table();

    // Sparse: st_val = 6'b100101.
    clear_table();
    val_t[0] = 1'b1; val_t[2] = 1'b1; val_t[5] = 1'b1; val_t[7] = 1'b1;
    d0 = done_cnt;
    start_table(6, 1'b0, 8'h33);
    wait_done(1'b0, 50);
    chk("sparse_count", 64'(got_idx.size()), 64'd3);
    if (got_idx.size() == 3) begin
      chk("sparse_idx0", 64'(got_idx[0]), 64'd0);
      chk("sparse_idx1", 64'(got_idx[1]), 64'd2);
      chk("sparse_idx2", 64'(got_idx[2]), 64'd5);
    end
    finish_table();
    chk("sparse_done_once", 64'(done_cnt - d0), 64'd1);

    // Backpressure: four valid entries, ready 1,0,0,1,...
    clear_table();
    for (int i = 0; i < 4; i++) val_t[i] = 1'b1;
    start_table(4, 1'b0, 8'h44);
    wait_done(1'b1, 80);
    chk("bp_count", 64'(got_idx.size()), 64'd4);
    for (int i = 0; i < got_idx.size(); i++) chk("bp_order", 64'(got_idx[i]), 64'(i));
    finish_table();

    // Empty table.
    clear_table();
    start_table(0, 1'b0, 8'h55);
    wait_done(1'b0, 20);
    chk("empty_no_val", 64'(first_val_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("empty_done_cyc", 64'(done_cyc - start_n), 64'd2);
    finish_table();

    // Build error.
    clear_table();
    for (int i = 0; i < 10; i++) val_t[i] = 1'b1;
    start_table(10, 1'b1, 8'h66);
    wait_done(1'b0, 20);
    chk("err_no_val", 64'(first_val_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("err_done_cyc", 64'(done_cyc - start_n), 64'd1);
    finish_table();

    // Clamp: wr_ptr above depth.
    clear_table();
    for (int i = 0; i < D; i++) val_t[i] = 1'b1;
    start_table(1023, 1'b0, 8'h77);
    wait_done(1'b0, 700);
    chk("clamp_count", 64'(got_idx.size()), 64'd584);
    if (got_idx.size() > 0) chk("clamp_last", 64'(got_idx[got_idx.size()-1]), 64'd583);
    finish_table();

    // Reset after two of five entries.
    clear_table();
    for (int i = 0; i < 5; i++) val_t[i] = 1'b1;
    d0 = done_cnt;
    start_table(5, 1'b0, 8'h88);
    a0 = acc_cnt;
    c = 0;
    while (c < 20 && acc_cnt - a0 < 2) begin
      @(posedge clk); #1;
      c++;
    end
    chk("pre_rst_accepts", 64'(acc_cnt - a0), 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_val", 64'(sa_val), 64'd0);
    chk("mid_rst_done", 64'(sa_st_read_done), 64'd0);
    chk("mid_rst_sym", 64'(sa_symbol), 64'd0);
    chk("mid_rst_idx", 64'(sa_index), 64'd0);
    chk("mid_rst_seq", 64'(sa_seq_id), 64'd0);
    chk("mid_rst_no_done", 64'(done_cnt), 64'(d0));
    build_model(5, 1'b0);
    got_idx.delete();
    rst = 1'b0;
    wait_done(1'b0, 50);
    chk("rst_restart_count", 64'(got_idx.size()), 64'd5);
    if (got_idx.size() > 0) chk("rst_restart_first", 64'(got_idx[0]), 64'd0);
    finish_table();
    chk("rst_done_once", 64'(done_cnt - d0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
